seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative restoring divider that inverts the 16x16 Wallace-tree multiplier: divides a 2W-bit dividend (a multiplier product) by a W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- Produces one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic block, and its bench reuses the multiplier's operand vectors for round-trip checks.

Parameters:
- WIDTH, 16, divisor, quotient and remainder width; the dividend is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  2*WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- ready  output  1  high in IDLE; start is accepted only when this is high.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  result; held stable from done until the next accepted start.
- remainder  output  WIDTH  result; held stable from done until the next accepted start.
- div_zero  output  1  divisor was 0; held like quotient.
- overflow  output  1  quotient does not fit in WIDTH bits; held like quotient.

Behaviour:
- Reset: on any edge with rst_n=0, regardless of state, go to IDLE.
  - Reset values: ready=1, busy=0, done=0, quotient=0, remainder=0, div_zero=0, overflow=0.
  - Reset mid-RUN aborts the operation; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k: latch the operands and clear div_zero/overflow.
  - If divisor==0: next state DONE with div_zero=1, quotient=all ones, remainder=dividend[WIDTH-1:0].
  - Else if dividend[2W-1:W] >= divisor: next state DONE with overflow=1, quotient=all ones, remainder=0.
  - Else: next state RUN. Load a (W+1)-bit partial remainder with dividend[2W-1:W], load the low half into a shift register, set the iteration counter to 0.
  - In both error cases done is high in the cycle after edge k, so latency is 1.
- RUN, each edge:
  - Form trial = {pr[W-1:0], msb of shift reg}, i.e. pr shifted left 1 with the next dividend bit in.
  - If trial >= divisor: pr = trial - divisor and shift 1 into the quotient LSB. Else: pr = trial and shift in 0.
  - Counter increments. After the WIDTH-th iteration (counter==WIDTH-1 at the edge), write quotient/remainder and go to DONE.
  - busy=1 and ready=0 throughout RUN.
  - Normal latency: done is high in the cycle after edge k+WIDTH (17 cycles for W=16).
- DONE: done=1, busy=0, ready=0 for exactly one cycle, then unconditionally IDLE. A start during DONE is ignored.
- start while busy or in DONE: ignored, with no effect on the in-flight operation or the outputs.
- Back-to-back operation: a start held high continuously is re-accepted on the first IDLE cycle after DONE.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Arithmetic: all unsigned.
  - The partial remainder is W+1 bits so the subtraction never wraps.
  - Final remainder < divisor. Invariant: quotient*divisor + remainder == dividend whenever overflow=0 and div_zero=0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. dividend=4294836225 (65535*65535), divisor=65535, start one cycle -> done 17 cycles later, quotient=65535, remainder=0, overflow=0, div_zero=0.
2. Multiplier round-trip: 625/25 -> q=25 r=0; 200/2 -> q=100 r=0; 91/2 -> q=45 r=1. Each start issued on the first IDLE cycle after the previous done; check that ready, busy and done sequence exactly.
3. divisor=0, dividend=32'h1234ABCD -> done 1 cycle after start, div_zero=1, quotient=16'hFFFF, remainder=16'hABCD. Separately: dividend=32'h00020000, divisor=2 -> overflow=1, quotient=16'hFFFF, remainder=0, latency 1.
4. Start 1000/7; pulse start with new operands 9/3 and change the operand pins at cycle 5 -> still q=142 r=6, exactly one done pulse, second request dropped.
5. Start 65535/255, assert rst_n=0 at cycle 8 for one cycle -> all outputs reset next cycle, no done. A new start 65535/255 afterwards -> q=257 r=0.
6. Randomised sweep of 2000 operand pairs with dividend[31:16] < divisor and divisor != 0 -> check the invariant q*d+r==dividend with r<d, and latency always 17.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder,
// one quotient bit per clock, start/ready/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  pr;       // partial remainder, always < dvsr between iterations
  logic [WIDTH-1:0]  lo_sr;    // dividend low half shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0]  dvsr;
  logic [CW-1:0]     cnt;

  logic [WIDTH:0]    trial;
  logic              trial_ge;
  logic [WIDTH-1:0]  pr_nxt;
  logic              accept, is_zero, is_ovf, last_iter;

  always_comb begin
    accept    = (state == IDLE) && start;
    is_zero   = (divisor == '0);
    is_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    // W+1-bit trial so the compare/subtract can never wrap
    trial     = {pr, lo_sr[WIDTH-1]};
    trial_ge  = (trial >= {1'b0, dvsr});
    pr_nxt    = trial_ge ? WIDTH'(trial - {1'b0, dvsr}) : trial[WIDTH-1:0];
    last_iter = (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
      RUN:  if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr        <= '0;
      lo_sr     <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvsr     <= divisor;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            if (is_zero) begin
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[WIDTH-1:0];
            end else if (is_ovf) begin
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              pr    <= dividend[2*WIDTH-1:WIDTH];
              lo_sr <= dividend[WIDTH-1:0];
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          pr    <= pr_nxt;
          lo_sr <= {lo_sr[WIDTH-2:0], trial_ge};
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quotient  <= {lo_sr[WIDTH-2:0], trial_ge};
            remainder <= pr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
